mux_scan_checker: RTL

Sequencer that sits directly upstream of the 4:1 LUT multiplexer (`mux4to1_lut`) and also consumes its output. It accepts a 4-bit data word over a valid/ready handshake and drives it onto the mux data inputs. It then steps the mux select through 0..3, holding each value for a programmable dwell, and samples the mux output at every step. The reassembled word is returned over a second valid/ready handshake, together with a mismatch flag and a saturating error count, for in-system self-check of the mux LUT.

---
 rtl/mux_scan_checker_if.sv | 30 +++
 rtl/mux_scan_checker.sv | 103 ++++++++++
 2 files changed

// File: rtl/mux_scan_checker_if.sv
// Handshake and mux-facing bus of the mux scan checker.
// master is the checker's view; slave is the upstream/downstream/mux side.
interface mux_scan_checker_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_data;
  logic [3:0]       mux_d;
  logic [1:0]       mux_sel;
  logic             mux_out;
  logic             res_valid;
  logic             res_ready;
  logic [3:0]       res_data;
  logic             res_mismatch;
  logic [CNT_W-1:0] err_count;
  logic             busy;

  modport master (
    input  in_valid, in_data, mux_out, res_ready,
    output in_ready, mux_d, mux_sel, res_valid, res_data, res_mismatch,
           err_count, busy
  );

  modport slave (
    output in_valid, in_data, mux_out, res_ready,
    input  in_ready, mux_d, mux_sel, res_valid, res_data, res_mismatch,
           err_count, busy
  );
endinterface

// File: rtl/mux_scan_checker.sv
// Drives a word onto a 4:1 mux, steps its select with a programmable dwell,
// reassembles the mux output and flags/counts words that do not read back.
module mux_scan_checker #(
  parameter int DWELL = 2,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_scan_checker_if.master bus
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_nx;
  logic [DW_W-1:0]  dwell_cnt;
  logic [3:0]       mux_d;
  logic [1:0]       mux_sel;
  logic [3:0]       res_data;
  logic [3:0]       res_sampled;
  logic [CNT_W-1:0] err_count;
  logic             dwell_end;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign dwell_end = (dwell_cnt == DW_W'(DWELL - 1));

  // Result word with the bit under the current select replaced by the live mux output
  always_comb begin
    res_sampled          = res_data;
    res_sampled[mux_sel] = bus.mux_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid)                      state_nx = SCAN;
      SCAN:    if (dwell_end && (mux_sel == 2'd3))    state_nx = DONE;
      DONE:    if (bus.res_ready)                     state_nx = IDLE;
      default:                                        state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.res_valid = (state == DONE);
    bus.busy      = (state == SCAN) || (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_d     <= '0;
      mux_sel   <= '0;
      dwell_cnt <= '0;
      res_data  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mux_d     <= bus.in_data;
            mux_sel   <= '0;
            dwell_cnt <= '0;
            res_data  <= '0;
          end
        end
        SCAN: begin
          if (dwell_end) begin
            res_data <= res_sampled;
            // Last bit lands now, so the count compares the completed word
            if (mux_sel == 2'd3) begin
              if (res_sampled != mux_d) err_count <= sat_inc(err_count);
            end else begin
              mux_sel   <= mux_sel + 2'd1;
              dwell_cnt <= '0;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.res_ready) mux_sel <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.mux_d        = mux_d;
  assign bus.mux_sel      = mux_sel;
  assign bus.res_data     = res_data;
  assign bus.res_mismatch = (res_data != mux_d);
  assign bus.err_count    = err_count;

endmodule
